// File: rtl/hazard_fwd_if.sv
// hazard_fwd_if: ID-side bundle between the decode stage and the hazard/forwarding unit.
// master = decode stage, slave = hazard_fwd_unit.
interface hazard_fwd_if #(
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic              id_rs1_used;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_is_load;
   logic              redirect;
   logic              stats_clr;
   logic              stall;
   logic              flush;
   logic [2:0]        fwd_sel1;
   logic [2:0]        fwd_sel2;
   logic              busy;
   logic [2:0]        inflight_cnt;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   modport master (
      output id_valid, id_rs1, id_rs1_used,
      output id_rs2, id_rs2_used, id_rd,
      output id_reg_write, id_is_load,
      output redirect, stats_clr,
      input  stall, flush, fwd_sel1, fwd_sel2,
      input  busy, inflight_cnt,
      input  stall_count, flush_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs1_used,
      input  id_rs2, id_rs2_used, id_rd,
      input  id_reg_write, id_is_load,
      input  redirect, stats_clr,
      output stall, flush, fwd_sel1, fwd_sel2,
      output busy, inflight_cnt,
      output stall_count, flush_count
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: scoreboard of in-flight writers, forwarding selects, load-use stall, flush.
// Define HAZARD_STATS_EN to add saturating stall/flush cycle counters.
module hazard_fwd_unit #(
   parameter int REG_AW   = 3,
   parameter int STAGES   = 3,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input logic         clk,
   input logic         rst,
   hazard_fwd_if.slave bus
);
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              wr;
      logic              ld;
   } ent_t;

   ent_t       pipe [1:STAGES];
   logic [2:0] sel1;
   logic [2:0] sel2;
   logic       ld1;
   logic       ld2;
   logic [3:0] n;
   logic       stall_i;
   logic       flush_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 1; k <= STAGES; k++)
            pipe[k] <= '0;
      end else begin
         for (int k = STAGES; k > 1; k--)
            pipe[k] <= pipe[k-1];
         pipe[1] <= '{
            valid: bus.id_valid & ~stall_i & ~bus.redirect,
            rd:    bus.id_rd,
            wr:    bus.id_reg_write,
            ld:    bus.id_is_load
         };
      end
   end

   // Walk oldest to youngest so the youngest producer wins.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      ld1  = 1'b0;
      ld2  = 1'b0;
      n    = '0;
      for (int k = STAGES; k >= 1; k--) begin
         if (bus.id_rs1_used && pipe[k].valid && pipe[k].wr &&
             pipe[k].rd == bus.id_rs1) begin
            sel1 = 3'(k);
            ld1  = pipe[k].ld && (k <= LOAD_LAT);
         end
         if (bus.id_rs2_used && pipe[k].valid && pipe[k].wr &&
             pipe[k].rd == bus.id_rs2) begin
            sel2 = 3'(k);
            ld2  = pipe[k].ld && (k <= LOAD_LAT);
         end
         n = n + 4'(pipe[k].valid);
      end
   end

   assign stall_i = ~rst & bus.id_valid & (ld1 | ld2) & ~bus.redirect;
   assign flush_i = ~rst & bus.redirect;

   assign bus.stall        = stall_i;
   assign bus.flush        = flush_i;
   assign bus.fwd_sel1     = rst ? 3'd0 : sel1;
   assign bus.fwd_sel2     = rst ? 3'd0 : sel2;
   assign bus.busy         = ~rst & (n != 4'd0);
   assign bus.inflight_cnt = rst ? 3'd0 :
                             (n > 4'd7) ? 3'd7 : n[2:0];

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] sc;
   logic [CNT_W-1:0] fc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sc <= '0;
         fc <= '0;
      end else if (bus.stats_clr) begin
         sc <= '0;
         fc <= '0;
      end else begin
         if (stall_i && !(&sc))
            sc <= sc + CNT_W'(1);
         if (flush_i && !(&fc))
            fc <= fc + CNT_W'(1);
      end
   end

   assign bus.stall_count = sc;
   assign bus.flush_count = fc;
`else
   logic unused_clr;
   assign unused_clr      = bus.stats_clr;
   assign bus.stall_count = '0;
   assign bus.flush_count = '0;
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: scoreboarded random + directed stimulus against a
// history-based reference model of in-flight writers.
module tb_hazard_fwd_unit;
   localparam int REG_AW   = 3;
   localparam int STAGES   = 3;
   localparam int LOAD_LAT = 1;
`ifdef HAZARD_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif
   localparam int MAXC = (1 << CNT_W) - 1;

   typedef struct packed {
      logic             stall;
      logic             flush;
      logic [2:0]       sel1;
      logic [2:0]       sel2;
      logic             busy;
      logic [2:0]       cnt;
      logic [CNT_W-1:0] sc;
      logic [CNT_W-1:0] fc;
   } exp_t;

   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } ent_s;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails = 0;
   int   sc_m = 0;
   int   fc_m = 0;
   exp_t expq [$];
   ent_s hist [$];

   hazard_fwd_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

   hazard_fwd_unit #(
      .REG_AW(REG_AW), .STAGES(STAGES),
      .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   // hist[k-1] is the instruction issued k cycles ago, i.e. now in stage k.
   function automatic void clear_model();
      hist.delete();
      for (int i = 0; i < STAGES; i++)
         hist.push_back('{0, 0, 0, 0});
      sc_m = 0;
      fc_m = 0;
   endfunction

   function automatic void youngest(input int rs, input bit used,
                                    output int sel, output bit isld);
      sel  = 0;
      isld = 0;
      if (used)
         for (int k = 1; k <= STAGES && sel == 0; k++)
            if (hist[k-1].v && hist[k-1].wr && hist[k-1].rd == rs) begin
               sel  = k;
               isld = hist[k-1].ld && k <= LOAD_LAT;
            end
   endfunction

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, got, want);
      end
   endtask

   task automatic drive_idle();
      bus.id_valid     = 0;
      bus.id_rs1       = '0;
      bus.id_rs1_used  = 0;
      bus.id_rs2       = '0;
      bus.id_rs2_used  = 0;
      bus.id_rd        = '0;
      bus.id_reg_write = 0;
      bus.id_is_load   = 0;
      bus.redirect     = 0;
      bus.stats_clr    = 0;
   endtask

   task automatic step(input bit v, input int r1, input bit u1,
                       input int r2, input bit u2, input int rd,
                       input bit wr, input bit ld, input bit rdr,
                       input bit clr);
      exp_t e;
      int   s1, s2, nv;
      bit   l1, l2, st;
      @(posedge clk);
      #1;
      bus.id_valid     = v;
      bus.id_rs1       = REG_AW'(r1);
      bus.id_rs1_used  = u1;
      bus.id_rs2       = REG_AW'(r2);
      bus.id_rs2_used  = u2;
      bus.id_rd        = REG_AW'(rd);
      bus.id_reg_write = wr;
      bus.id_is_load   = ld;
      bus.redirect     = rdr;
      bus.stats_clr    = clr;
      youngest(r1, u1, s1, l1);
      youngest(r2, u2, s2, l2);
      st = v && (l1 || l2) && !rdr;
      nv = 0;
      foreach (hist[i]) nv += int'(hist[i].v);
      e.stall = st;
      e.flush = rdr;
      e.sel1  = 3'(s1);
      e.sel2  = 3'(s2);
      e.busy  = nv > 0;
      e.cnt   = 3'(nv > 7 ? 7 : nv);
      e.sc    = CNT_W'(sc_m);
      e.fc    = CNT_W'(fc_m);
      expq.push_back(e);
`ifdef HAZARD_STATS_EN
      if (clr) begin
         sc_m = 0;
         fc_m = 0;
      end else begin
         if (st && sc_m != MAXC) sc_m++;
         if (rdr && fc_m != MAXC) fc_m++;
      end
`endif
      hist.push_front('{v && !st && !rdr, rd, wr, ld});
      void'(hist.pop_back());
   endtask

   initial begin : monitor
      exp_t e;
      exp_t a;
      forever begin
         @(negedge clk);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            a.stall = bus.stall;
            a.flush = bus.flush;
            a.sel1  = bus.fwd_sel1;
            a.sel2  = bus.fwd_sel2;
            a.busy  = bus.busy;
            a.cnt   = bus.inflight_cnt;
            a.sc    = bus.stall_count;
            a.fc    = bus.flush_count;
            checks++;
            if (a !== e) begin
               fails++;
               $display("FAIL cycle t=%0t: got st=%0b fl=%0b s1=%0d s2=%0d bz=%0b n=%0d sc=%0d fc=%0d expected st=%0b fl=%0b s1=%0d s2=%0d bz=%0b n=%0d sc=%0d fc=%0d",
                  $time, a.stall, a.flush, a.sel1, a.sel2, a.busy, a.cnt,
                  a.sc, a.fc, e.stall, e.flush, e.sel1, e.sel2, e.busy,
                  e.cnt, e.sc, e.fc);
            end
         end
      end
   end

   initial begin : stim
      drive_idle();
      clear_model();
      #2;
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_cnt", int'(bus.inflight_cnt), 0);
      chk("reset_stall", int'(bus.stall), 0);
      chk("reset_sc", int'(bus.stall_count), 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // ALU chain
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      // load-use, held for the stall
      step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      step(1, 0, 0, 2, 1, 6, 1, 0, 0, 0);
      step(1, 0, 0, 2, 1, 6, 1, 0, 0, 0);
      // youngest wins, unused source ignored
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
      step(1, 5, 1, 5, 0, 0, 0, 0, 0, 0);
      // redirect during load-use
      step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
      step(1, 4, 1, 0, 0, 7, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // async reset with three entries and a pending stall
      step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
      step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      drive_idle();
      rst = 1;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_stall", int'(bus.stall), 0);
      chk("arst_cnt", int'(bus.inflight_cnt), 0);
      chk("arst_sel1", int'(bus.fwd_sel1), 0);
      @(posedge clk);
      #1 rst = 0;
      clear_model();

      // stall run to saturate, then clear with a stall
      step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(1, 6, 1, 0, 0, 6, 1, 1, 0, 0);
         step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      end
      step(1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 6, 1, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      step(1, 6, 1, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(7, 0) != 0,
              $urandom_range(3, 0), $urandom_range(1, 0) == 1,
              $urandom_range(3, 0), $urandom_range(1, 0) == 1,
              $urandom_range(3, 0), $urandom_range(3, 0) != 0,
              $urandom_range(2, 0) == 0,
              $urandom_range(9, 0) == 0,
              $urandom_range(19, 0) == 0);

      @(negedge clk);
      #1;
      chk("queue_drained", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised pipeline hazard and forwarding controller for the 8-bit, 19-bit-instruction pipelined core. Tracks destination registers in flight through EX..WB in a scoreboard shift register. Generates operand forwarding selects, load-use stalls and branch/jump/return flushes, which the current pipeline lacks. Sits beside the ID stage and drives the pipeline-register enables and the ALU operand muxes.

Parameters:
REG_AW, 3, register-address width (2**REG_AW registers)
STAGES, 3, in-flight stages tracked after ID (1=EX ... STAGES=WB); legal 2..7
LOAD_LAT, 1, highest stage index at which a load result is not yet forwardable; legal 1..STAGES-1
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_AW  source register 1
id_rs1_used  in  1  rs1 is read
id_rs2  in  REG_AW  source register 2
id_rs2_used  in  1  rs2 is read
id_rd  in  REG_AW  destination register
id_reg_write  in  1  instruction writes id_rd
id_is_load  in  1  result comes from data memory
redirect  in  1  taken branch/jump/return resolved in EX this cycle
stall  out  1  hold PC and IF/ID; insert bubble into ID/EX
flush  out  1  squash IF/ID and ID/EX
fwd_sel1  out  3  0=register file, k=forward from stage k
fwd_sel2  out  3  as fwd_sel1 for rs2
busy  out  1  any valid entry in flight (halt drain)
inflight_cnt  out  3  number of valid entries
stats_clr  in  1  synchronous clear of statistics counters
stall_count  out  CNT_W  stall cycles (optional feature)
flush_count  out  CNT_W  flush cycles (optional feature)

Behaviour:
- Scoreboard entries pipe[1..STAGES], each {valid, rd, wr, is_load}; pipe[1]=EX, pipe[STAGES]=WB.
- Every rising edge: pipe[k+1] <= pipe[k]; the entry leaving pipe[STAGES] is dropped.
- pipe[1] <= {1, id_rd, id_reg_write, id_is_load} if id_valid & !stall & !redirect; otherwise a bubble (valid=0).
- Match(k, rs, used) = used & pipe[k].valid & pipe[k].wr & pipe[k].rd==rs. No register is special; register 0 is forwarded like any other.
- fwd_selN = smallest k with a match (youngest producer wins); 0 if none. Combinational from the scoreboard and ID inputs, zero-latency.
- Load-use: stall_raw = id_valid & (for rs1 or rs2: the youngest match k has pipe[k].is_load & k<=LOAD_LAT).
  - A younger non-load match shadows an older load, so no stall in that case.
- stall = stall_raw & !redirect; flush = redirect. Redirect wins over stall in the same cycle.
- A stall lasts until the load advances past LOAD_LAT: exactly LOAD_LAT-k+1 cycles for a load at stage k.
- Forwarding from pipe[STAGES] covers the write-then-read in the same cycle at the register file.
- busy = OR of pipe[*].valid; inflight_cnt = popcount of the valid bits, saturating at 7.
- Reset (asynchronous, any time, including mid-stall): all entries invalid; stall, flush, fwd_sel*, busy and inflight_cnt are 0 immediately; counters are 0.
- Outputs are 0 while rst is high regardless of inputs.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_count increments on every cycle with stall=1; flush_count increments on every cycle with flush=1.
  - Both saturate at all-ones.
  - stats_clr zeroes both on the next edge; a clear has priority over an increment in the same cycle.
- Undefined: stall_count and flush_count are tied to 0, stats_clr is ignored and no counter flops are present. Port list is identical in both builds.

Test Plan:
- ALU chain: issue rd=3 wr=1, next cycle ID rs1=3 used -> fwd_sel1=1, stall=0; one cycle later with no new writer -> fwd_sel1=2.
- Load-use, LOAD_LAT=1: load rd=2, next ID rs2=2 used -> stall=1 for exactly 1 cycle, bubble in pipe[1]; the following cycle -> fwd_sel2=2, stall=0.
- Youngest wins: rd=5 writers at stage 3 and stage 1, ID rs1=5 -> fwd_sel1=1; unused source (rs2_used=0, rs2=5) -> fwd_sel2=0.
- Redirect during load-use: load rd=4 in stage 1, ID reads r4, redirect=1 -> flush=1, stall=0; next edge pipe[1].valid=0, inflight_cnt unchanged from the previous count of real entries.
- Async reset mid-stream with 3 valid entries and stall=1: raise rst between edges -> busy=0, stall=0, inflight_cnt=0 with no clock edge.
- HAZARD_STATS_EN, CNT_W=2: 5 stall cycles -> stall_count=3 (saturated); 2 flushes -> flush_count=2; stats_clr together with a stall -> both 0.
